// File: rtl/lif_tdm_scheduler.sv
// Time-division leaky-integrate-and-fire scheduler: one shared update datapath
// visits N_NEURONS virtual neurons round-robin in two-cycle FETCH/COMMIT slots.
module lif_tdm_scheduler #(
    parameter int               N_NEURONS = 4,
    parameter int               IDX_W     = $clog2(N_NEURONS),
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] THRESH    = 8'd100,
    parameter logic [WIDTH-1:0] ADD       = 8'd5,
    parameter logic [WIDTH-1:0] LEAK      = 8'd1,
    parameter logic [WIDTH-1:0] VRESET    = 8'd0,
    parameter int               REFRACT   = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [N_NEURONS-1:0] signal_in,
    output logic [N_NEURONS-1:0] spike_out,
    output logic                 sweep_done,
    output logic [IDX_W-1:0]     cur_idx,
    input  logic [IDX_W-1:0]     rd_idx,
    output logic [WIDTH-1:0]     rd_vmem
);

    localparam int RW = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_FETCH  = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;

    localparam logic [IDX_W-1:0] IDX_ZERO  = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1'b1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_NEURONS - 1);
    localparam logic [RW-1:0]    REFR_LOAD = RW'(REFRACT);
    localparam logic [RW-1:0]    REFR_ZERO = {RW{1'b0}};
    localparam logic [RW-1:0]    REFR_ONE  = RW'(1'b1);

    // Unsigned add that clamps at the all-ones value instead of wrapping.
    function automatic logic [WIDTH-1:0] sat_add(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        logic [WIDTH:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s[WIDTH]) begin
            sat_add = {WIDTH{1'b1}};
        end else begin
            sat_add = s[WIDTH-1:0];
        end
    endfunction

    // Unsigned subtract that floors at zero.
    function automatic logic [WIDTH-1:0] floor_sub(input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b);
        if (a >= b) begin
            floor_sub = a - b;
        end else begin
            floor_sub = {WIDTH{1'b0}};
        end
    endfunction

    logic [1:0]           r_state;
    logic [IDX_W-1:0]     r_idx;
    logic [WIDTH-1:0]     r_vmem [N_NEURONS];
    logic [RW-1:0]        r_refr [N_NEURONS];
    logic [N_NEURONS-1:0] r_pend;
    logic [WIDTH-1:0]     r_v;
    logic                 r_p;
    logic [RW-1:0]        r_r;
    logic [N_NEURONS-1:0] r_spike;
    logic                 r_sweep_done;
    logic [WIDTH-1:0]     r_rd_vmem;

    logic [1:0]           w_state_nxt;
    logic [IDX_W-1:0]     w_idx_nxt;
    logic                 w_last;
    logic                 w_commit;
    logic [WIDTH-1:0]     w_inc;
    logic [WIDTH-1:0]     w_dec;
    logic [WIDTH-1:0]     w_n;
    logic                 w_fire;
    logic [N_NEURONS-1:0] w_clr;

    // Slot sequencing: IDLE -> FETCH -> COMMIT, wrapping at the last neuron.
    always_comb begin
        w_last      = (r_idx == LAST_IDX);
        w_commit    = (r_state == ST_COMMIT);
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        case (r_state)
            ST_IDLE: begin
                w_idx_nxt = IDX_ZERO;
                if (en) begin
                    w_state_nxt = ST_FETCH;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_FETCH: begin
                w_state_nxt = ST_COMMIT;
            end
            ST_COMMIT: begin
                if (w_last) begin
                    w_idx_nxt = IDX_ZERO;
                    if (en) begin
                        w_state_nxt = ST_FETCH;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_idx_nxt   = r_idx + IDX_ONE;
                    w_state_nxt = ST_FETCH;
                end
            end
            default: begin
                w_idx_nxt   = IDX_ZERO;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Shared integrate/leak/threshold datapath operating on the fetched neuron.
    always_comb begin
        w_inc = sat_add(r_v, ADD);
        w_dec = floor_sub(r_v, LEAK);
        if (r_p) begin
            w_n = w_inc;
        end else begin
            w_n = w_dec;
        end
        w_fire = w_commit && (r_r == REFR_ZERO) && (w_n >= THRESH);
        w_clr  = {N_NEURONS{1'b0}};
        if (w_commit) begin
            w_clr[r_idx] = 1'b1;
        end else begin
            w_clr = {N_NEURONS{1'b0}};
        end
    end

    // FSM state and current slot index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_idx   <= IDX_ZERO;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // Event capture; a new event in the COMMIT cycle outlives the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend <= {N_NEURONS{1'b0}};
        end else begin
            r_pend <= (r_pend & ~w_clr) | signal_in;
        end
    end

    // Working copy of the serviced neuron, latched during FETCH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v <= VRESET;
            r_p <= 1'b0;
            r_r <= REFR_ZERO;
        end else if (r_state == ST_FETCH) begin
            r_v <= r_vmem[r_idx];
            r_p <= r_pend[r_idx];
            r_r <= r_refr[r_idx];
        end
    end

    // Per-neuron write-back in COMMIT; refractory takes priority over input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_NEURONS; i++) begin
                r_vmem[i] <= VRESET;
                r_refr[i] <= REFR_ZERO;
            end
        end else if (w_commit) begin
            if (r_r != REFR_ZERO) begin
                r_vmem[r_idx] <= VRESET;
                r_refr[r_idx] <= r_r - REFR_ONE;
            end else if (w_fire) begin
                r_vmem[r_idx] <= VRESET;
                r_refr[r_idx] <= REFR_LOAD;
            end else begin
                r_vmem[r_idx] <= w_n;
            end
        end
    end

    // Registered pulses and debug readout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_spike      <= {N_NEURONS{1'b0}};
            r_sweep_done <= 1'b0;
            r_rd_vmem    <= VRESET;
        end else begin
            r_spike      <= {N_NEURONS{1'b0}};
            r_sweep_done <= w_commit && w_last;
            r_rd_vmem    <= r_vmem[rd_idx];
            if (w_fire) begin
                r_spike[r_idx] <= 1'b1;
            end
        end
    end

    assign spike_out  = r_spike;
    assign sweep_done = r_sweep_done;
    assign cur_idx    = r_idx;
    assign rd_vmem    = r_rd_vmem;

endmodule

// File: tb/tb_lif_tdm_scheduler.sv
// Directed bench for lif_tdm_scheduler: default instance plus a saturation
// instance (ADD=200, THRESH=255); expected values are hand-computed cycle positions.
module tb_lif_tdm_scheduler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [3:0] signal_in, spike_out;
    logic       sweep_done;
    logic [1:0] cur_idx, rd_idx;
    logic [7:0] rd_vmem;

    logic [3:0] sig_sat, spike_sat;
    logic       sweep_sat;
    logic [1:0] idx_sat, rd_idx_sat;
    logic [7:0] rd_sat;

    int n_vec = 0;
    int n_err = 0;
    int pos   = 0;

    lif_tdm_scheduler u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .signal_in  (signal_in),
        .spike_out  (spike_out),
        .sweep_done (sweep_done),
        .cur_idx    (cur_idx),
        .rd_idx     (rd_idx),
        .rd_vmem    (rd_vmem)
    );

    lif_tdm_scheduler #(.ADD(8'd200), .THRESH(8'd255)) u_sat (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .signal_in  (sig_sat),
        .spike_out  (spike_sat),
        .sweep_done (sweep_sat),
        .cur_idx    (idx_sat),
        .rd_idx     (rd_idx_sat),
        .rd_vmem    (rd_sat)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // pos counts posedges since reset release; we always stand on a negedge.
    task automatic adv_to(input int k);
        while (pos < k) begin
            @(negedge clk);
            pos++;
        end
    endtask

    initial begin
        int s;
        int e;
        rst_n = 1'b0; en = 1'b0; signal_in = 4'd0; sig_sat = 4'd0;
        rd_idx = 2'd0; rd_idx_sat = 2'd0;
        repeat (2) @(negedge clk);
        check_val("rst_spike", 32'(spike_out), 32'd0);
        check_val("rst_sweep", 32'(sweep_done), 32'd0);
        check_val("rst_idx", 32'(cur_idx), 32'd0);
        check_val("rst_rdvmem", 32'(rd_vmem), 32'd0);

        // Phase A: neuron 0 held high -> integrate to fire, then refractory.
        signal_in = 4'b0001; sig_sat = 4'b0001; en = 1'b1; rst_n = 1'b1; pos = 0;
        for (int p = 1; p <= 190; p++) begin
            adv_to(p);
            if (p == 3) check_val("idx_adv", 32'(cur_idx), 32'd1);
            if (p == 9) check_val("sweep_hi", 32'(sweep_done), 32'd1);
            if (p == 10) check_val("sweep_lo", 32'(sweep_done), 32'd0);
            if (p % 8 == 4 && p <= 148) check_val("vmem0_int", 32'(rd_vmem), 32'(5 * ((p + 4) / 8)));
            if (p % 8 == 3 && p > 3 && p < 155) check_val("no_early_spike", 32'(spike_out), 32'd0);
            if (p == 155) check_val("spike0", 32'(spike_out), 32'd1);
            if (p == 156) begin
                check_val("spike0_end", 32'(spike_out), 32'd0);
                check_val("vmem0_reset", 32'(rd_vmem), 32'd0);
                rd_idx = 2'd1;
            end
            if (p == 157) begin check_val("vmem1_idle", 32'(rd_vmem), 32'd0); rd_idx = 2'd2; end
            if (p == 158) begin check_val("vmem2_idle", 32'(rd_vmem), 32'd0); rd_idx = 2'd3; end
            if (p == 159) begin check_val("vmem3_idle", 32'(rd_vmem), 32'd0); rd_idx = 2'd0; end
            if (p == 164 || p == 172 || p == 180) check_val("refr_hold", 32'(rd_vmem), 32'd0);
            if (p % 8 == 3 && p > 155) check_val("refr_nospike", 32'(spike_out), 32'd0);
            if (p == 188) check_val("refr_resume", 32'(rd_vmem), 32'd5);
            if (p == 4) check_val("sat_first", 32'(rd_sat), 32'd200);
            if (p == 11) check_val("sat_spike", 32'(spike_sat), 32'd1);
            if (p == 12) check_val("sat_reset", 32'(rd_sat), 32'd0);
        end

        // Phase B: leak floor, set-wins, en drop, reset mid-COMMIT.
        rst_n = 1'b0; en = 1'b0; signal_in = 4'd0; sig_sat = 4'd0; rd_idx = 2'd2;
        repeat (2) @(negedge clk);
        en = 1'b1; rst_n = 1'b1; pos = 0;
        for (int p = 1; p <= 198; p++) begin
            adv_to(p);
            if (p <= 18 && p % 8 == 1) signal_in[2] = 1'b1;
            if (p <= 18 && p % 8 == 2) signal_in[2] = 1'b0;
            if (p % 8 == 0 && p <= 160) begin
                s = p / 8 - 1;
                if (s <= 2) e = 5 * (s + 1);
                else if (s <= 17) e = 17 - s;
                else e = 0;
                check_val("leak_floor", 32'(rd_vmem), 32'(e));
            end
            if (p % 8 == 7 && p <= 159) check_val("leak_nospike", 32'(spike_out), 32'd0);
            if (p == 165) rd_idx = 2'd3;
            if (p == 168) signal_in[3] = 1'b1;
            if (p == 169) signal_in[3] = 1'b0;
            if (p == 170) check_val("setwins_commit", 32'(rd_vmem), 32'd0);
            if (p == 177) signal_in[2] = 1'b1;
            if (p == 178) begin
                check_val("setwins_next", 32'(rd_vmem), 32'd5);
                signal_in[2] = 1'b0;
                rd_idx = 2'd2;
            end
            if (p == 180) begin check_val("en_drop_idx", 32'(cur_idx), 32'd1); en = 1'b0; end
            if (p == 184) check_val("slot2_commit", 32'(rd_vmem), 32'd5);
            if (p == 185) begin
                check_val("drop_sweep_hi", 32'(sweep_done), 32'd1);
                check_val("drop_idx_wrap", 32'(cur_idx), 32'd0);
            end
            if (p == 186) check_val("drop_sweep_lo", 32'(sweep_done), 32'd0);
            if (p == 193) check_val("idle_no_sweep", 32'(sweep_done), 32'd0);
            if (p == 194) begin
                check_val("idle_retain", 32'(rd_vmem), 32'd5);
                check_val("idle_idx", 32'(cur_idx), 32'd0);
            end
            if (p == 196) en = 1'b1;
        end
        check_val("pre_rst_vmem", 32'(rd_vmem), 32'd5);
        #2 rst_n = 1'b0;
        #1;
        check_val("async_rd", 32'(rd_vmem), 32'd0);
        check_val("async_spike", 32'(spike_out), 32'd0);
        check_val("async_sweep", 32'(sweep_done), 32'd0);
        check_val("async_idx", 32'(cur_idx), 32'd0);
        repeat (2) @(negedge clk);
        en = 1'b0; rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            rd_idx = 2'(k);
            @(negedge clk);
            check_val("post_rst_vmem", 32'(rd_vmem), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
